// File: rtl/ddr_pkg.sv
// Shared definitions for the arrow-key debouncer: default lane count,
// lane state encoding and the agreement-counter width helper.
package ddr_pkg;

    localparam int N_KEYS_DEF = 4;

    typedef enum logic {
        RELEASED = 1'b0,
        HELD     = 1'b1
    } lane_state_e;

    // Bits needed to count 0..stable_cnt consecutive differing samples.
    function automatic int cnt_width(input int stable_cnt);
        return (stable_cnt < 1) ? 1 : $clog2(stable_cnt + 1);
    endfunction

endpackage

// File: rtl/key_debounce_lane.sv
// One key lane: 2-flop synchronizer, agreement counter, RELEASED/HELD FSM
// and, when KEY_AUTOREPEAT_EN is defined, the auto-repeat counter.
module key_debounce_lane
    import ddr_pkg::*;
#(
    parameter int STABLE_CNT   = 3,
    parameter int REPEAT_DELAY = 16,
    parameter int REPEAT_RATE  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic strobe,
    input  logic key_raw_n,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam int CW = cnt_width(STABLE_CNT);

    if (STABLE_CNT < 1 || STABLE_CNT > 15 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
        $error("key_debounce_lane: parameter out of range");
    end

    logic [1:0]    sync_q;
    logic          key_now;
    lane_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          accept;

`ifdef KEY_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          rep_first_q, rep_first_d;
`endif

    assign key_now = ~sync_q[1];

    // NOTE: the synchronizer resets to 1 (released) so a key held through
    // reset is seen as a fresh press rather than as a level already accepted.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q    <= 2'b11;
            state_q   <= RELEASED;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], key_raw_n};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
        end
    end
`endif

    // NOTE: every variable gets a default at the top of the block so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        accept    = 1'b0;

        if (strobe) begin
            if (key_now != (state_q == HELD)) begin
                if (cnt_q == CW'(STABLE_CNT - 1)) begin
                    accept = 1'b1;
                    cnt_d  = '0;
                    if (state_q == RELEASED) begin
                        state_d = HELD;
                        press_d = 1'b1;
                    end else begin
                        state_d   = RELEASED;
                        release_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else begin
                cnt_d = '0;
            end
        end

`ifdef KEY_AUTOREPEAT_EN
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        if (accept && state_q == RELEASED) begin
            rep_cnt_d   = '0;
            rep_first_d = 1'b1;
        end else if (strobe && state_q == HELD && !accept) begin
            // A release accepted on the same strobe wins over a repeat pulse.
            rep_cnt_d = rep_cnt_q + RW'(1);
            if (rep_cnt_d == (rep_first_q ? RW'(REPEAT_DELAY) : RW'(REPEAT_RATE))) begin
                press_d     = 1'b1;
                rep_cnt_d   = '0;
                rep_first_d = 1'b0;
            end
        end
`endif
    end

    assign key_level   = (state_q == HELD);
    assign key_press   = press_q;
    assign key_release = release_q;

endmodule

// File: rtl/key_debouncer.sv
// Arrow-key debouncer top: shared sample strobe from tick_src rising edges
// feeding N_KEYS independent lanes. Auto-repeat enabled by KEY_AUTOREPEAT_EN.
module key_debouncer
    import ddr_pkg::*;
#(
    parameter int N_KEYS       = N_KEYS_DEF,
    parameter int STABLE_CNT   = 3,
    parameter int REPEAT_DELAY = 16,
    parameter int REPEAT_RATE  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_src,
    input  logic [N_KEYS-1:0] key_raw_n,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release
);

    logic tick_q;
    logic strobe;

    // Edge register resets high so releasing reset while tick_src is high
    // waits for the next true rising edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tick_q <= 1'b1;
        else        tick_q <= tick_src;
    end

    assign strobe = tick_src & ~tick_q;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_lane
        key_debounce_lane #(
            .STABLE_CNT  (STABLE_CNT),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE)
        ) u_lane (
            .clk        (clk),
            .reset      (reset),
            .strobe     (strobe),
            .key_raw_n  (key_raw_n[i]),
            .key_level  (key_level[i]),
            .key_press  (key_press[i]),
            .key_release(key_release[i])
        );
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Scoreboard bench for key_debouncer: expected pulses (masks and strobe
// index) are queued by the stimulus and matched by a negedge monitor.
module tb_key_debouncer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] div = 2'd0;
    logic       tick_src;
    logic [3:0] key_raw_n = 4'b1111;
    logic [3:0] key_level, key_press, key_release;
    int         strobe_n;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0] press;
        logic [3:0] rel;
        int         strobe;
    } exp_t;

    exp_t exp_q[$];

    key_debouncer #(
        .N_KEYS      (4),
        .STABLE_CNT  (3),
        .REPEAT_DELAY(16),
        .REPEAT_RATE (4)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .tick_src   (tick_src),
        .key_raw_n  (key_raw_n),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release)
    );

    always #5 clk = ~clk;

    always @(posedge clk) div <= div + 2'd1;
    assign tick_src = div[1];

    // Strobe index as the DUT should see it: sampled on the edge ending div==2.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)         strobe_n <= 0;
        else if (div == 2'd2) strobe_n <= strobe_n + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic expect_evt(input logic [3:0] press, input logic [3:0] rel, input int s);
        exp_t e;
        e.press  = press;
        e.rel    = rel;
        e.strobe = s;
        exp_q.push_back(e);
    endtask

    // Monitor: every pulse cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && (key_press != 4'b0 || key_release != 4'b0)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_pulse: press=%b release=%b at strobe %0d, expected none",
                         key_press, key_release, strobe_n);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("press_mask", 32'(key_press), 32'(e.press));
                check("release_mask", 32'(key_release), 32'(e.rel));
                check("pulse_strobe", 32'(strobe_n), 32'(e.strobe));
            end
        end
    end

    task automatic wait_phase();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (div == 2'd3) return;
        end
        check("phase_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_strobes(input int n);
        int target;
        target = strobe_n + n;
        for (int i = 0; i < n * 4 + 8; i++) begin
            @(negedge clk);
            if (strobe_n == target && div == 2'd3) return;
        end
        check("strobe_timeout", 32'(strobe_n), 32'(target));
    endtask

    initial begin
        int s;

        // Reset state, with key 0 already held.
        key_raw_n = 4'b1110;
        repeat (3) @(negedge clk);
        check("rst_level", 32'(key_level), 32'd0);
        check("rst_press", 32'(key_press), 32'd0);
        check("rst_release", 32'(key_release), 32'd0);

        // Held through reset release (tick_src high): accepted on strobe 3.
        wait_phase();
        rst_n = 1'b1;
        expect_evt(4'b0001, 4'b0000, 3);
        wait_strobes(4);
        check("held_thru_reset_level", 32'(key_level), 32'b0001);
        key_raw_n = 4'b1111;
        expect_evt(4'b0000, 4'b0001, 7);
        wait_strobes(4);
        check("k0_released_level", 32'(key_level), 32'd0);
        check("pending_1", 32'(exp_q.size()), 32'd0);

        // Bounce: toggle key 0 every strobe, nothing accepted.
        for (int i = 0; i < 10; i++) begin
            key_raw_n[0] = ~key_raw_n[0];
            wait_strobes(1);
        end
        wait_strobes(3);
        check("bounce_level", 32'(key_level), 32'd0);
        check("pending_2", 32'(exp_q.size()), 32'd0);

        // Key 2 pressed for 8 strobes, then released.
        s = strobe_n;
        key_raw_n = 4'b1011;
        expect_evt(4'b0100, 4'b0000, s + 3);
        wait_strobes(8);
        check("k2_level", 32'(key_level), 32'b0100);
        key_raw_n = 4'b1111;
        expect_evt(4'b0000, 4'b0100, s + 11);
        wait_strobes(4);
        check("k2_released_level", 32'(key_level), 32'd0);
        check("pending_3", 32'(exp_q.size()), 32'd0);

        // All keys in the same clk.
        s = strobe_n;
        key_raw_n = 4'b0000;
        expect_evt(4'b1111, 4'b0000, s + 3);
        wait_strobes(4);
        check("all_level", 32'(key_level), 32'b1111);
        key_raw_n = 4'b1111;
        expect_evt(4'b0000, 4'b1111, s + 7);
        wait_strobes(4);
        check("all_released_level", 32'(key_level), 32'd0);
        check("pending_4", 32'(exp_q.size()), 32'd0);

        // Key 1 held 40 strobes; release acceptance coincides with a repeat slot.
        s = strobe_n;
        key_raw_n = 4'b1101;
        expect_evt(4'b0010, 4'b0000, s + 3);
`ifdef KEY_AUTOREPEAT_EN
        for (int k = 19; k <= 39; k += 4) expect_evt(4'b0010, 4'b0000, s + k);
`endif
        wait_strobes(40);
        check("k1_level", 32'(key_level), 32'b0010);
        key_raw_n = 4'b1111;
        expect_evt(4'b0000, 4'b0010, s + 43);
        wait_strobes(5);
        check("k1_released_level", 32'(key_level), 32'd0);
        check("pending_5", 32'(exp_q.size()), 32'd0);

        // Reset while key 3 held: level clears at once, no release pulse.
        s = strobe_n;
        key_raw_n = 4'b0111;
        expect_evt(4'b1000, 4'b0000, s + 3);
        wait_strobes(4);
        check("k3_level", 32'(key_level), 32'b1000);
        #2 rst_n = 1'b0;
        #1 check("async_rst_level", 32'(key_level), 32'd0);
        check("async_rst_release", 32'(key_release), 32'd0);
        repeat (3) @(negedge clk);
        key_raw_n = 4'b1111;
        wait_phase();
        rst_n = 1'b1;
        wait_strobes(6);
        check("post_rst_level", 32'(key_level), 32'd0);
        check("pending_6", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
